// File: rtl/joy_pkg.sv
// Shared definitions for the joypad serial port: pad FSM states, command
// bytes and poll length. The serial controller bench uses the same package.
package joy_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
        ACK_WAIT  = 3'd2,
        ACK_PULSE = 3'd3,
        IGNORE    = 3'd4,
        DONE      = 3'd5
    } pad_state_t;

    localparam logic [7:0] JOY_CMD_SELECT = 8'h01;
    localparam logic [7:0] JOY_CMD_READ   = 8'h42;
    localparam int         JOY_POLL_BYTES = 5;

    // Reply byte for a given byte index of the digital-pad poll.
    // Buttons are active high on the pad side and active low on the wire.
    function automatic logic [7:0] pad_reply(input logic [2:0]  idx,
                                             input logic [15:0] pad_id,
                                             input logic [15:0] btn);
        logic [7:0] r;
        r = 8'hFF;
        case (idx)
            3'd0:    r = 8'hFF;
            3'd1:    r = pad_id[7:0];
            3'd2:    r = pad_id[15:8];
            3'd3:    r = ~btn[7:0];
            3'd4:    r = ~btn[15:8];
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/joy_in_sync.sv
// N-stage synchronizer for one asynchronous input line.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output (RST_VAL while in reset)
// STAGES must be 2 or 3.
module joy_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/joy_pad_responder.sv
// Device-side digital pad on the joypad serial port. Answers the 5-byte
// poll (01, 42, xx, xx, xx) LSB first in mode-3 timing: reply bits change on
// the falling edge of joy_clk, command bits are sampled on the rising edge.
// After each of bytes 0..3 an /ACK pulse is produced.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   joy_att      : /ATT select, low = selected
//   joy_clk      : serial clock from controller, idles high
//   joy_cmd      : serial command, LSB first
//   buttons      : pad buttons, 1 = pressed
//   joy_data     : serial reply, 1 when released
//   joy_ack      : /ACK, low = acknowledge
//   xfer_active  : 1 while a poll is in progress
//   last_cmd     : most recently completed command byte
//   cmd_err      : one-cycle pulse on an unexpected byte 0 / byte 1
//   state_dbg    : current FSM state (pad_state_t encoding)
module joy_pad_responder
    import joy_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter int          ACK_DELAY   = 100,
    parameter int          ACK_WIDTH   = 50,
    parameter logic [15:0] PAD_ID      = 16'h5A41
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        joy_att,
    input  logic        joy_clk,
    input  logic        joy_cmd,
    input  logic [15:0] buttons,
    output logic        joy_data,
    output logic        joy_ack,
    output logic        xfer_active,
    output logic [7:0]  last_cmd,
    output logic        cmd_err,
    output logic [2:0]  state_dbg
);

    // Handshake with the controller: the host owns joy_clk/joy_cmd, the pad
    // answers on joy_data and acknowledges each byte (except the last) with a
    // low pulse on joy_ack; the host may start the next byte at any time.

    localparam int ACK_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int ACK_CW  = $clog2(ACK_MAX + 1);

    logic att_s, clk_s, cmd_s;
    logic att_d, clk_d;

    joy_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_att (
        .clk(clk), .rst_n(rst_n), .d(joy_att), .q(att_s)
    );
    joy_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
        .clk(clk), .rst_n(rst_n), .d(joy_clk), .q(clk_s)
    );
    joy_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cmd (
        .clk(clk), .rst_n(rst_n), .d(joy_cmd), .q(cmd_s)
    );

    logic att_fall, att_rise, clk_fall, clk_rise;
    assign att_fall = att_d & ~att_s;
    assign att_rise = ~att_d & att_s;
    assign clk_fall = clk_d & ~clk_s;
    assign clk_rise = ~clk_d & clk_s;

    pad_state_t        state;
    logic [2:0]        byte_idx;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_shift;
    logic [6:0]        rx_shift;   // first seven bits of the current byte
    logic [15:0]       btn_lat;
    logic [ACK_CW-1:0] ack_cnt;

    // Complete byte as it stands on the eighth rising edge.
    logic [7:0] rx_byte;
    assign rx_byte = {cmd_s, rx_shift};

    logic cmd_ok;
    assign cmd_ok = !(((byte_idx == 3'd0) && (rx_byte != JOY_CMD_SELECT)) ||
                      ((byte_idx == 3'd1) && (rx_byte != JOY_CMD_READ)));

    // Bit shifting happens in SHIFT, and also in the ack states when the
    // host clocks the next byte early: that edge both ends the ack phase
    // and counts as the first edge of the new byte.
    logic shift_en;
    assign shift_en = (state == SHIFT) ||
                      (((state == ACK_WAIT) || (state == ACK_PULSE)) &&
                       (clk_fall || clk_rise));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            att_d    <= 1'b1;
            clk_d    <= 1'b1;
            state    <= IDLE;
            byte_idx <= 3'd0;
            bit_cnt  <= 3'd0;
            tx_shift <= 8'hFF;
            rx_shift <= 7'd0;
            btn_lat  <= 16'd0;
            ack_cnt  <= '0;
            joy_data <= 1'b1;
            joy_ack  <= 1'b1;
            last_cmd <= 8'd0;
            cmd_err  <= 1'b0;
        end else begin
            att_d   <= att_s;
            clk_d   <= clk_s;
            cmd_err <= 1'b0;

            if (att_rise) begin
                // Deselect aborts everything; last_cmd is kept.
                state    <= IDLE;
                byte_idx <= 3'd0;
                bit_cnt  <= 3'd0;
                tx_shift <= 8'hFF;
                rx_shift <= 7'd0;
                ack_cnt  <= '0;
                joy_data <= 1'b1;
                joy_ack  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (att_fall) begin
                            state    <= SHIFT;
                            btn_lat  <= buttons;
                            byte_idx <= 3'd0;
                            bit_cnt  <= 3'd0;
                            rx_shift <= 7'd0;
                            tx_shift <= pad_reply(3'd0, PAD_ID, buttons);
                        end
                    end
                    ACK_WAIT: begin
                        if (clk_fall || clk_rise) begin
                            state   <= SHIFT;
                            ack_cnt <= '0;
                        end else if (ack_cnt == ACK_CW'(ACK_DELAY - 1)) begin
                            state   <= ACK_PULSE;
                            joy_ack <= 1'b0;
                            ack_cnt <= '0;
                        end else if (ack_cnt != ACK_CW'(ACK_MAX)) begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                    ACK_PULSE: begin
                        if (clk_fall || clk_rise) begin
                            state   <= SHIFT;
                            joy_ack <= 1'b1;
                            ack_cnt <= '0;
                        end else if (ack_cnt == ACK_CW'(ACK_WIDTH - 1)) begin
                            state   <= SHIFT;
                            joy_ack <= 1'b1;
                            ack_cnt <= '0;
                        end else if (ack_cnt != ACK_CW'(ACK_MAX)) begin
                            ack_cnt <= ack_cnt + 1'b1;
                        end
                    end
                    IGNORE, DONE: begin
                        joy_data <= 1'b1;
                    end
                    default: begin
                        // SHIFT: edge handling below
                    end
                endcase

                if (shift_en) begin
                    if (clk_fall) begin
                        joy_data <= tx_shift[0];
                        tx_shift <= {1'b1, tx_shift[7:1]};
                    end
                    if (clk_rise) begin
                        rx_shift <= {cmd_s, rx_shift[6:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            last_cmd <= rx_byte;
                            ack_cnt  <= '0;
                            if (!cmd_ok) begin
                                state    <= IGNORE;
                                cmd_err  <= 1'b1;
                                joy_data <= 1'b1;
                            end else if (byte_idx == 3'(JOY_POLL_BYTES - 1)) begin
                                state    <= DONE;
                                joy_data <= 1'b1;
                            end else begin
                                // Next reply is staged now so an early host
                                // edge during the ack phase finds it ready.
                                state    <= ACK_WAIT;
                                byte_idx <= byte_idx + 3'd1;
                                tx_shift <= pad_reply(byte_idx + 3'd1, PAD_ID, btn_lat);
                            end
                        end
                    end
                end
            end
        end
    end

    assign xfer_active = (state != IDLE) && (state != IGNORE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_joy_pad_responder.sv
module tb_joy_pad_responder;
    import joy_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int ACK_DELAY   = 100;
    localparam int ACK_WIDTH   = 50;
    localparam int HALF        = 8;   // clk cycles per joy_clk half period
    // Host raises joy_clk -> two synchronizer flops -> edge-detect register:
    // the pad acts on the third system clock edge after the host edge.
    localparam int EXP_ACK_LAT = ACK_DELAY + SYNC_STAGES + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        joy_att = 1'b1;
    logic        joy_clk = 1'b1;
    logic        joy_cmd = 1'b1;
    logic [15:0] buttons = 16'd0;
    logic        joy_data;
    logic        joy_ack;
    logic        xfer_active;
    logic [7:0]  last_cmd;
    logic        cmd_err;
    logic [2:0]  state_dbg;

    joy_pad_responder #(
        .SYNC_STAGES(SYNC_STAGES),
        .ACK_DELAY  (ACK_DELAY),
        .ACK_WIDTH  (ACK_WIDTH),
        .PAD_ID     (16'h5A41)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .joy_att    (joy_att),
        .joy_clk    (joy_clk),
        .joy_cmd    (joy_cmd),
        .buttons    (buttons),
        .joy_data   (joy_data),
        .joy_ack    (joy_ack),
        .xfer_active(xfer_active),
        .last_cmd   (last_cmd),
        .cmd_err    (cmd_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitors ----------------
    int   cyc = 0;
    int   last_raise_cyc = 0;
    int   ack_fall_cyc = 0;
    int   ack_rise_cyc = 0;
    int   ack_falls = 0;
    int   ack_rises = 0;
    int   err_cycles = 0;
    logic ack_prev = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ack_prev && !joy_ack) begin ack_fall_cyc = cyc; ack_falls++; end
            if (!ack_prev && joy_ack) begin ack_rise_cyc = cyc; ack_rises++; end
            if (cmd_err) err_cycles++;
        end
        ack_prev = joy_ack;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- host driver tasks ----------------
    // All tasks start and end right after a negedge of clk.
    task automatic bit_cycle(input logic c, output logic d);
        joy_clk = 1'b0;
        joy_cmd = c;
        repeat (HALF) @(negedge clk);
        d = joy_data;
        joy_clk = 1'b1;
        last_raise_cyc = cyc;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] cmd, output logic [7:0] rx);
        logic b;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(cmd[i], b);
            rx[i] = b;
        end
    endtask

    task automatic wait_ack(input int r0, input string name);
        for (int i = 0; i < 400 && ack_rises <= r0; i++) @(negedge clk);
        check(name, 32'(ack_rises > r0), 32'd1);
    endtask

    task automatic select_pad(input logic [15:0] btn);
        buttons = btn;
        joy_att = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic deselect_check(input string tag);
        joy_att = 1'b1;
        repeat (6) @(negedge clk);
        check({tag, "_idle_state"}, 32'(state_dbg), 32'(IDLE));
        check({tag, "_idle_data"}, 32'(joy_data), 32'd1);
        check({tag, "_idle_ack"}, 32'(joy_ack), 32'd1);
        check({tag, "_idle_xfer"}, 32'(xfer_active), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] btn;       // buttons at selection
        logic [15:0] btn_mid;   // buttons after the pad has latched them
        logic [39:0] cmds;      // byte 0 in the top byte
        logic [39:0] reps;      // expected replies, byte 0 in the top byte
        logic [7:0]  exp_last;
        int          nacks;
        int          nerr;
    } vec_t;

    vec_t vecs[7];

    task automatic run_poll(input vec_t v, input string tag);
        logic [7:0] rx;
        int a0, e0, r0;
        select_pad(v.btn);
        check({tag, "_xfer_active"}, 32'(xfer_active), 32'd1);
        buttons = v.btn_mid;
        a0 = ack_rises;
        e0 = err_cycles;
        for (int k = 0; k < JOY_POLL_BYTES; k++) begin
            r0 = ack_rises;
            send_byte(v.cmds[39-8*k -: 8], rx);
            check($sformatf("%s_reply%0d", tag, k), 32'(rx), 32'(v.reps[39-8*k -: 8]));
            if (k < v.nacks) begin
                wait_ack(r0, $sformatf("%s_ack%0d_seen", tag, k));
                check($sformatf("%s_ack%0d_delay", tag, k),
                      32'(ack_fall_cyc - last_raise_cyc), 32'(EXP_ACK_LAT));
                check($sformatf("%s_ack%0d_width", tag, k),
                      32'(ack_rise_cyc - ack_fall_cyc), 32'(ACK_WIDTH));
            end else begin
                repeat (ACK_DELAY + ACK_WIDTH) @(negedge clk);
            end
        end
        check({tag, "_last_cmd"}, 32'(last_cmd), 32'(v.exp_last));
        check({tag, "_ack_count"}, 32'(ack_rises - a0), 32'(v.nacks));
        check({tag, "_err_cycles"}, 32'(err_cycles - e0), 32'(v.nerr));
        deselect_check(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] rx;
        logic       b;
        int         n;

        vecs[0] = '{16'h0009, 16'h0009, {8'h01, 8'h42, 8'h00, 8'h00, 8'h00},
                    {8'hFF, 8'h41, 8'h5A, 8'hF6, 8'hFF}, 8'h00, 4, 0};
        vecs[1] = '{16'h0009, 16'hFFFF, {8'h01, 8'h42, 8'h00, 8'h00, 8'h00},
                    {8'hFF, 8'h41, 8'h5A, 8'hF6, 8'hFF}, 8'h00, 4, 0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, {8'h01, 8'h42, 8'h00, 8'h00, 8'h00},
                    {8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00}, 8'h00, 4, 0};
        vecs[3] = '{16'h8001, 16'h8001, {8'h01, 8'h42, 8'hAA, 8'h55, 8'h3C},
                    {8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F}, 8'h3C, 4, 0};
        vecs[4] = '{16'h0000, 16'h0000, {8'h81, 8'h42, 8'h00, 8'h00, 8'h00},
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'h81, 0, 1};
        vecs[5] = '{16'h0000, 16'h0000, {8'h01, 8'h42, 8'h00, 8'h00, 8'h00},
                    {8'hFF, 8'h41, 8'h5A, 8'hFF, 8'hFF}, 8'h00, 4, 0};
        vecs[6] = '{16'h1234, 16'h1234, {8'h01, 8'h43, 8'h00, 8'h00, 8'h00},
                    {8'hFF, 8'h41, 8'hFF, 8'hFF, 8'hFF}, 8'h43, 1, 1};

        // Reset
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_joy_data", 32'(joy_data), 32'd1);
        check("rst_joy_ack", 32'(joy_ack), 32'd1);
        check("rst_xfer_active", 32'(xfer_active), 32'd0);
        check("rst_last_cmd", 32'(last_cmd), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));

        // Table-driven polls
        for (int i = 0; i < 7; i++) run_poll(vecs[i], $sformatf("vec%0d", i));

        // Deselect in the middle of byte 2 (after bit 3)
        select_pad(16'h0009);
        n = ack_rises;
        send_byte(8'h01, rx);
        wait_ack(n, "abort_ack0_seen");
        n = ack_rises;
        send_byte(8'h42, rx);
        wait_ack(n, "abort_ack1_seen");
        for (int i = 0; i < 4; i++) bit_cycle(1'b0, b);
        joy_att = 1'b1;
        n = 0;
        while (state_dbg != 3'(IDLE) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_idle_within_sync", 32'(n <= SYNC_STAGES + 1), 32'd1);
        check("abort_last_cmd_kept", 32'(last_cmd), 32'h42);
        check("abort_joy_data", 32'(joy_data), 32'd1);
        check("abort_joy_ack", 32'(joy_ack), 32'd1);
        repeat (4) @(negedge clk);
        run_poll(vecs[0], "after_abort");

        // Host starts byte 2 while /ACK for byte 1 is still low
        select_pad(16'h0009);
        n = ack_rises;
        send_byte(8'h01, rx);
        wait_ack(n, "early_ack0_seen");
        send_byte(8'h42, rx);
        check("early_reply1", 32'(rx), 32'h41);
        for (int i = 0; i < 300 && joy_ack; i++) @(negedge clk);
        check("early_ack_low", 32'(joy_ack), 32'd0);
        repeat (5) @(negedge clk);
        joy_clk = 1'b0;
        joy_cmd = 1'b0;
        repeat (SYNC_STAGES) @(negedge clk);
        check("early_ack_before_edge", 32'(joy_ack), 32'd0);
        @(negedge clk);
        check("early_ack_released", 32'(joy_ack), 32'd1);
        repeat (HALF - SYNC_STAGES - 1) @(negedge clk);
        rx[0] = joy_data;
        joy_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            bit_cycle(1'b0, b);
            rx[i] = b;
        end
        check("early_reply2", 32'(rx), 32'h5A);
        n = ack_rises;
        wait_ack(n, "early_ack2_seen");
        n = ack_rises;
        send_byte(8'h00, rx);
        check("early_reply3", 32'(rx), 32'hF6);
        wait_ack(n, "early_ack3_seen");
        send_byte(8'h00, rx);
        check("early_reply4", 32'(rx), 32'hFF);
        repeat (20) @(negedge clk);
        deselect_check("early");

        // Reset in the middle of byte 1 while joy_data is driven low
        select_pad(16'h0009);
        n = ack_rises;
        send_byte(8'h01, rx);
        wait_ack(n, "mrst_ack0_seen");
        bit_cycle(1'b0, b);
        bit_cycle(1'b1, b);
        check("mrst_data_low_before", 32'(joy_data), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mrst_joy_data", 32'(joy_data), 32'd1);
        check("mrst_joy_ack", 32'(joy_ack), 32'd1);
        check("mrst_xfer_active", 32'(xfer_active), 32'd0);
        check("mrst_last_cmd", 32'(last_cmd), 32'd0);
        joy_att = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_poll(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
